// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: grants one of N requesters a tenure of up to
// max(weight,1) cycles, then rotates priority past the last winner.
module wrr_arbiter #(
   parameter  int N  = 4,
   parameter  int WW = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [N-1:0]    req_i,
   input  logic [N*WW-1:0] weight_i,
   output logic [N-1:0]    gnt_o,
   output logic [IW-1:0]   gnt_id_o,
   output logic            gnt_vld_o
);

   typedef enum logic {ST_IDLE, ST_GRANT} state_t;

   state_t          r_state, w_state_next;
   logic [N-1:0]    r_gnt, w_gnt_next;
   logic [IW-1:0]   r_gnt_id, w_gnt_id_next;
   logic [IW-1:0]   r_ptr, w_ptr_next;
   logic [WW-1:0]   r_credit, w_credit_next;
   logic [IW-1:0]   w_base;
   logic [IW-1:0]   w_win;
   logic            w_found;
   logic            w_hold;
   logic [WW-1:0]   w_fresh;
   logic [WW-1:0]   w_weight [N];

   for (genvar gi = 0; gi < N; gi++) begin : g_weight
      assign w_weight[gi] = weight_i[gi*WW +: WW];
   end

   // While granting, the current owner is the pointer a release rotates past.
   assign w_base = (r_state == ST_GRANT) ? r_gnt_id : r_ptr;

   // Descending scan so the nearest requester after w_base is written last.
   always_comb begin
      logic [IW-1:0] v_idx;
      w_found = 1'b0;
      w_win   = '0;
      v_idx   = '0;
      for (int k = N; k >= 1; k--) begin
         v_idx = IW'((int'(w_base) + k) % N);
         if (req_i[v_idx]) begin
            w_found = 1'b1;
            w_win   = v_idx;
         end
      end
   end

   assign w_fresh = (w_weight[w_win] == '0) ? '0 : w_weight[w_win] - WW'(1);
   assign w_hold  = req_i[r_gnt_id] && (r_credit != '0);

   always_comb begin
      w_state_next  = r_state;
      w_gnt_next    = r_gnt;
      w_gnt_id_next = r_gnt_id;
      w_ptr_next    = r_ptr;
      w_credit_next = r_credit;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_state_next  = ST_GRANT;
               w_gnt_next    = N'(1) << w_win;
               w_gnt_id_next = w_win;
               w_credit_next = w_fresh;
            end
         end
         ST_GRANT: begin
            if (w_hold) begin
               w_credit_next = r_credit - WW'(1);
            end else begin
               w_ptr_next = r_gnt_id;
               if (w_found) begin
                  w_gnt_next    = N'(1) << w_win;
                  w_gnt_id_next = w_win;
                  w_credit_next = w_fresh;
               end else begin
                  w_state_next  = ST_IDLE;
                  w_gnt_next    = '0;
                  w_gnt_id_next = '0;
                  w_credit_next = '0;
               end
            end
         end
         default: begin
            w_state_next  = ST_IDLE;
            w_gnt_next    = '0;
            w_gnt_id_next = '0;
            w_credit_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= ST_IDLE;
         r_gnt    <= '0;
         r_gnt_id <= '0;
         r_ptr    <= IW'(N - 1);
         r_credit <= '0;
      end else begin
         r_state  <= w_state_next;
         r_gnt    <= w_gnt_next;
         r_gnt_id <= w_gnt_id_next;
         r_ptr    <= w_ptr_next;
         r_credit <= w_credit_next;
      end
   end

   assign gnt_o     = r_gnt;
   assign gnt_id_o  = r_gnt_id;
   assign gnt_vld_o = |r_gnt;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Bench for wrr_arbiter (N=4, WW=4): scenario tasks with a reference-model
// scoreboard, fixed expectation tables and continuous grant invariants.
module tb_wrr_arbiter;

   localparam int N  = 4;
   localparam int WW = 4;

   logic          clk_i;
   logic          rst_i;
   logic [N-1:0]  req_i;
   logic [N*WW-1:0] weight_i;
   logic [N-1:0]  gnt_o;
   logic [1:0]    gnt_id_o;
   logic          gnt_vld_o;

   wrr_arbiter #(.N(N), .WW(WW)) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .req_i     (req_i),
      .weight_i  (weight_i),
      .gnt_o     (gnt_o),
      .gnt_id_o  (gnt_id_o),
      .gnt_vld_o (gnt_vld_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [3:0] gnt;
      logic [1:0] id;
      logic       vld;
   } exp_t;

   exp_t sb_q[$];
   int   n_pass  = 0;
   int   n_total = 0;
   int   cyc     = 0;
   bit   chk_en  = 1'b0;

   // Reference model: owner, cycles used in this tenure, tenure length, last winner.
   int m_owner = -1;
   int m_used  = 0;
   int m_wt    = 1;
   int m_last  = N - 1;

   task automatic drive(input logic r, input logic [3:0] rq, input logic [15:0] wt);
      exp_t e;
      rst_i    = r;
      req_i    = rq;
      weight_i = wt;
      if (r) begin
         m_owner = -1;
         m_last  = N - 1;
      end else if (m_owner >= 0 && rq[m_owner] && m_used < m_wt) begin
         m_used++;
      end else begin
         if (m_owner >= 0) m_last = m_owner;
         m_owner = -1;
         for (int k = 1; k <= N; k++) begin
            int p;
            p = (m_last + k) % N;
            if (m_owner < 0 && rq[p]) m_owner = p;
         end
         if (m_owner >= 0) begin
            m_wt   = int'(wt[m_owner*4 +: 4]);
            if (m_wt == 0) m_wt = 1;
            m_used = 1;
         end
      end
      e.gnt = (m_owner >= 0) ? (4'(1) << m_owner) : 4'b0000;
      e.id  = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
      e.vld = (m_owner >= 0);
      sb_q.push_back(e);
      @(posedge clk_i);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 4'b1111, 16'h1111);
         e = sb_q.pop_front();
         n_total++;
         if (gnt_o === 4'b0000 && gnt_id_o === 2'd0 && gnt_vld_o === 1'b0 && e.vld === 1'b0) begin
            n_pass++;
            $display("pass reset cyc=%0d gnt=%b id=%0d vld=%b", cyc, gnt_o, gnt_id_o, gnt_vld_o);
         end else begin
            $display("FAIL reset cyc=%0d got gnt=%b id=%0d vld=%b need 0000/0/0", cyc, gnt_o, gnt_id_o, gnt_vld_o);
         end
      end
   endtask

   task automatic test_rotate_unit_weights();
      exp_t e;
      logic [3:0] want;
      drive(1'b1, 4'b0000, 16'h1111); void'(sb_q.pop_front());
      drive(1'b0, 4'b0000, 16'h1111);
      e = sb_q.pop_front();
      n_total++;
      if (gnt_o === 4'b0000 && gnt_vld_o === 1'b0 && e.vld === 1'b0) n_pass++;
      else $display("FAIL rotate_idle got gnt=%b vld=%b need 0000/0", gnt_o, gnt_vld_o);
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 4'b1111, 16'h1111);
         e    = sb_q.pop_front();
         want = 4'b0001 << (i % 4);
         n_total++;
         if (gnt_o === want && e.gnt === want && gnt_id_o === e.id && gnt_vld_o === 1'b1) begin
            n_pass++;
            $display("pass rotate cyc=%0d gnt=%b id=%0d", cyc, gnt_o, gnt_id_o);
         end else begin
            $display("FAIL rotate cyc=%0d got gnt=%b id=%0d vld=%b need gnt=%b id=%0d", cyc, gnt_o, gnt_id_o, gnt_vld_o, want, e.id);
         end
      end
   endtask

   task automatic test_weighted_period();
      exp_t e;
      int   ids [10] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3};
      drive(1'b1, 4'b0000, 16'h4321); void'(sb_q.pop_front());
      for (int i = 0; i < 20; i++) begin
         drive(1'b0, 4'b1111, 16'h4321);
         e = sb_q.pop_front();
         n_total++;
         if (gnt_id_o === 2'(ids[i % 10]) && gnt_o === e.gnt && gnt_id_o === e.id && gnt_vld_o === 1'b1) begin
            n_pass++;
            $display("pass weighted cyc=%0d gnt=%b id=%0d", cyc, gnt_o, gnt_id_o);
         end else begin
            $display("FAIL weighted cyc=%0d got gnt=%b id=%0d need id=%0d", cyc, gnt_o, gnt_id_o, ids[i % 10]);
         end
      end
   endtask

   task automatic test_drop_request();
      exp_t e;
      logic [3:0] rq  [5] = '{4'b0011, 4'b0011, 4'b0010, 4'b0010, 4'b0010};
      logic [3:0] gw  [5] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010};
      drive(1'b1, 4'b0000, 16'h1114); void'(sb_q.pop_front());
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, rq[i], 16'h1114);
         e = sb_q.pop_front();
         n_total++;
         if (gnt_o === gw[i] && gnt_o === e.gnt && gnt_id_o === e.id && gnt_vld_o === 1'b1) begin
            n_pass++;
            $display("pass drop cyc=%0d req=%b gnt=%b", cyc, rq[i], gnt_o);
         end else begin
            $display("FAIL drop cyc=%0d req=%b got gnt=%b id=%0d need gnt=%b", cyc, rq[i], gnt_o, gnt_id_o, gw[i]);
         end
      end
   endtask

   task automatic test_single_requester();
      exp_t e;
      drive(1'b1, 4'b0000, 16'h0200); void'(sb_q.pop_front());
      for (int i = 0; i < 7; i++) begin
         drive(1'b0, 4'b0100, 16'h0200);
         e = sb_q.pop_front();
         n_total++;
         if (gnt_o === 4'b0100 && gnt_id_o === 2'd2 && gnt_vld_o === 1'b1 && e.gnt === 4'b0100) begin
            n_pass++;
            $display("pass single cyc=%0d gnt=%b id=%0d", cyc, gnt_o, gnt_id_o);
         end else begin
            $display("FAIL single cyc=%0d got gnt=%b id=%0d vld=%b need 0100/2/1", cyc, gnt_o, gnt_id_o, gnt_vld_o);
         end
      end
   endtask

   task automatic test_zero_weight_and_idle();
      exp_t e;
      logic [3:0] rq [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
      logic [3:0] gw [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
      drive(1'b1, 4'b0000, 16'h1101); void'(sb_q.pop_front());
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, rq[i], 16'h1101);
         e = sb_q.pop_front();
         n_total++;
         if (gnt_o === gw[i] && gnt_vld_o === (|gw[i]) && gnt_o === e.gnt && gnt_id_o === e.id) begin
            n_pass++;
            $display("pass zero_wt cyc=%0d req=%b gnt=%b vld=%b", cyc, rq[i], gnt_o, gnt_vld_o);
         end else begin
            $display("FAIL zero_wt cyc=%0d got gnt=%b vld=%b need gnt=%b", cyc, gnt_o, gnt_vld_o, gw[i]);
         end
      end
   endtask

   task automatic test_reset_mid_tenure();
      exp_t e;
      logic       rs [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      logic [3:0] rq [4] = '{4'b1000, 4'b1000, 4'b1111, 4'b1111};
      logic [3:0] gw [4] = '{4'b1000, 4'b1000, 4'b0000, 4'b0001};
      drive(1'b1, 4'b0000, 16'h4111); void'(sb_q.pop_front());
      for (int i = 0; i < 4; i++) begin
         drive(rs[i], rq[i], 16'h4111);
         e = sb_q.pop_front();
         n_total++;
         if (gnt_o === gw[i] && gnt_vld_o === (|gw[i]) && gnt_o === e.gnt && gnt_id_o === e.id) begin
            n_pass++;
            $display("pass rst_mid cyc=%0d rst=%b gnt=%b id=%0d", cyc, rs[i], gnt_o, gnt_id_o);
         end else begin
            $display("FAIL rst_mid cyc=%0d rst=%b got gnt=%b id=%0d need gnt=%b", cyc, rs[i], gnt_o, gnt_id_o, gw[i]);
         end
      end
   endtask

   task automatic test_random();
      exp_t e;
      logic [3:0]  rq = 4'b1111;
      logic [15:0] wt = 16'h1234;
      drive(1'b1, 4'b0000, wt); void'(sb_q.pop_front());
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
         if ($urandom_range(0, 7) == 0) wt = 16'($urandom);
         drive(1'b0, rq, wt);
         e = sb_q.pop_front();
         n_total++;
         if (gnt_o === e.gnt && gnt_id_o === e.id && gnt_vld_o === e.vld) begin
            n_pass++;
            $display("pass random cyc=%0d req=%b gnt=%b id=%0d", cyc, rq, gnt_o, gnt_id_o);
         end else begin
            $display("FAIL random cyc=%0d req=%b got gnt=%b id=%0d vld=%b need gnt=%b id=%0d vld=%b",
                     cyc, rq, gnt_o, gnt_id_o, gnt_vld_o, e.gnt, e.id, e.vld);
         end
      end
   endtask

   // Invariants sampled mid-cycle: grant shape, owner legality, starvation bound.
   logic [3:0] prev_req;
   int         wait_cnt [N];
   initial for (int i = 0; i < N; i++) wait_cnt[i] = 0;
   always @(posedge clk_i) prev_req <= req_i;

   always @(negedge clk_i) begin
      if (chk_en) begin
         n_total++;
         if (($countones(gnt_o) <= 1) && (gnt_vld_o === (|gnt_o)) &&
             (!gnt_vld_o || gnt_o === (4'b0001 << gnt_id_o)) &&
             ((gnt_o & ~prev_req) === 4'b0000)) begin
            n_pass++;
         end else begin
            $display("FAIL invariant cyc=%0d gnt=%b id=%0d vld=%b prev_req=%b", cyc, gnt_o, gnt_id_o, gnt_vld_o, prev_req);
         end
         for (int i = 0; i < N; i++) begin
            if (req_i[i] && !gnt_o[i] && !rst_i) wait_cnt[i]++;
            else wait_cnt[i] = 0;
         end
         n_total++;
         if (wait_cnt[0] <= 64 && wait_cnt[1] <= 64 && wait_cnt[2] <= 64 && wait_cnt[3] <= 64) n_pass++;
         else $display("FAIL starvation cyc=%0d waits=%0d,%0d,%0d,%0d limit 64", cyc, wait_cnt[0], wait_cnt[1], wait_cnt[2], wait_cnt[3]);
      end
   end

   initial begin
      rst_i    = 1'b1;
      req_i    = '0;
      weight_i = '0;
      test_reset();
      chk_en = 1'b1;
      test_rotate_unit_weights();
      test_weighted_period();
      test_drop_request();
      test_single_requester();
      test_zero_weight_and_idle();
      test_reset_mid_tenure();
      test_random();
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
